// File: rtl/vga_timing_dither.sv
// vga_timing_dither
//   Parametrised VGA timing generator feeding an external pixel source,
//   followed by an ordered (8x8 Bayer) dither stage that reduces IN_BITS
//   of colour per channel to OUT_BITS and drives the VGA pins.
//
// Optional feature macro: VGA_TEMPORAL_DITHER_EN
//   When defined, the Bayer coordinates are perturbed by the aligned frame
//   counter so the pattern cycles over 4 frames. When undefined the pattern
//   is static (the frame output is still counted).
//
// Ports
//   clk48        pixel clock
//   rst          asynchronous reset, active-high
//   h_count      horizontal counter to the pixel source
//   v_count      vertical counter to the pixel source
//   line_start   high while h_count == 0 (low in reset)
//   frame_start  high while h_count == 0 and v_count == 0 (low in reset)
//   frame        2-bit frame counter
//   pix_r/g/b    colour from the source, valid PIPE_LAT cycles after counters
//   pix_valid    1 = pixel covered, 0 = black
//   hsync/vsync  registered syncs, active level SYNC_POL
//   r/g/b_out    registered dithered colour

module vga_timing_dither #(
    parameter int H_DISPLAY = 1220,
    parameter int H_FRONT   = 31,
    parameter int H_SYNC    = 183,
    parameter int H_TOTAL   = 1525,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_TOTAL   = 525,
    parameter int IN_BITS   = 6,
    parameter int OUT_BITS  = 2,
    parameter int PIPE_LAT  = 2,
    parameter bit SYNC_POL  = 1'b0
) (
    input  logic                clk48,
    input  logic                rst,
    output logic [10:0]         h_count,
    output logic [9:0]          v_count,
    output logic                line_start,
    output logic                frame_start,
    output logic [1:0]          frame,
    input  logic [IN_BITS-1:0]  pix_r,
    input  logic [IN_BITS-1:0]  pix_g,
    input  logic [IN_BITS-1:0]  pix_b,
    input  logic                pix_valid,
    output logic                hsync,
    output logic                vsync,
    output logic [OUT_BITS-1:0] r_out,
    output logic [OUT_BITS-1:0] g_out,
    output logic [OUT_BITS-1:0] b_out
);

    localparam int D = IN_BITS - OUT_BITS;

    localparam logic [10:0] H_LAST    = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_ACT_END = 11'(H_DISPLAY);
    localparam logic [10:0] HS_START  = 11'(H_DISPLAY + H_FRONT);
    localparam logic [10:0] HS_END    = 11'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [9:0]  V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_ACT_END = 10'(V_DISPLAY);
    localparam logic [9:0]  VS_START  = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0]  VS_END    = 10'(V_DISPLAY + V_FRONT + V_SYNC);

    localparam logic [IN_BITS:0] OUT_MAX = (IN_BITS + 1)'((1 << OUT_BITS) - 1);

`ifdef VGA_TEMPORAL_DITHER_EN
    localparam logic TEMPORAL = 1'b1;
`else
    localparam logic TEMPORAL = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Counters
    // ------------------------------------------------------------------
    logic [10:0] h_q, h_d;
    logic [9:0]  v_q, v_d;
    logic [1:0]  frame_q, frame_d;

    always_comb begin
        h_d     = h_q + 11'd1;
        v_d     = v_q;
        frame_d = frame_q;
        if (h_q == H_LAST) begin
            h_d = '0;
            if (v_q == V_LAST) begin
                v_d     = '0;
                frame_d = frame_q + 2'd1;
            end else begin
                v_d = v_q + 10'd1;
            end
        end
    end

    always_ff @(posedge clk48 or posedge rst) begin
        if (rst) begin
            h_q     <= '0;
            v_q     <= '0;
            frame_q <= '0;
        end else begin
            h_q     <= h_d;
            v_q     <= v_d;
            frame_q <= frame_d;
        end
    end

    assign h_count = h_q;
    assign v_count = v_q;
    assign frame   = frame_q;

    // Counters sit at zero during reset; keep the strobes quiet until release.
    assign line_start  = ~rst & (h_q == '0);
    assign frame_start = ~rst & (h_q == '0) & (v_q == '0);

    // ------------------------------------------------------------------
    // Raw timing and alignment with the pixel source
    // ------------------------------------------------------------------
    logic active_w, hs_w, vs_w;

    assign active_w = (h_q < H_ACT_END) && (v_q < V_ACT_END);
    assign hs_w     = (h_q >= HS_START) && (h_q < HS_END);
    assign vs_w     = (v_q >= VS_START) && (v_q < VS_END);

    localparam int DW = 11;

    // Sync flags are carried as "in sync" (not pin level), so an all-zero
    // stage is blank with syncs inactive regardless of SYNC_POL.
    logic [DW-1:0] raw_w, aligned_w;

    assign raw_w = {active_w, hs_w, vs_w, h_q[2:0], v_q[2:0], frame_q};

    generate
        if (PIPE_LAT == 0) begin : g_no_delay
            assign aligned_w = raw_w;
        end else begin : g_delay
            logic [DW-1:0] dly_q [PIPE_LAT];

            always_ff @(posedge clk48 or posedge rst) begin
                if (rst) begin
                    for (int k = 0; k < PIPE_LAT; k++) begin
                        dly_q[k] <= '0;
                    end
                end else begin
                    dly_q[0] <= raw_w;
                    for (int k = 1; k < PIPE_LAT; k++) begin
                        dly_q[k] <= dly_q[k-1];
                    end
                end
            end

            assign aligned_w = dly_q[PIPE_LAT-1];
        end
    endgenerate

    logic       act_al, hs_al, vs_al;
    logic [2:0] hl_al, vl_al;
    logic [1:0] fr_al;

    assign {act_al, hs_al, vs_al, hl_al, vl_al, fr_al} = aligned_w;

    // ------------------------------------------------------------------
    // Ordered dither
    // ------------------------------------------------------------------
    logic [2:0] bi, bj, ba;
    logic [5:0] bayer;

    // With the temporal option off TEMPORAL is 0 and the frame bits drop out.
    assign bi    = hl_al ^ {2'b00, fr_al[0] & TEMPORAL};
    assign bj    = vl_al ^ {2'b00, fr_al[1] & TEMPORAL};
    assign ba    = bi ^ bj;
    // Bit-reversed interleave of (i^j, i) gives the 8x8 Bayer index.
    assign bayer = {ba[0], bi[0], ba[1], bi[1], ba[2], bi[2]};

    // Threshold is the top D bits of the Bayer index; the sum is one bit
    // wider than the colour so bright pixels saturate instead of wrapping.
    function automatic logic [OUT_BITS-1:0] dither_ch(input logic [IN_BITS-1:0] c,
                                                       input logic [5:0]         m);
        logic [5:0]       t;
        logic [IN_BITS:0] sum;
        logic [IN_BITS:0] q;
        t   = m >> (6 - D);
        sum = {1'b0, c} + (IN_BITS + 1)'(t);
        q   = sum >> D;
        if (q > OUT_MAX) begin
            return OUT_MAX[OUT_BITS-1:0];
        end
        return q[OUT_BITS-1:0];
    endfunction

    // ------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------
    logic                hsync_q, hsync_d;
    logic                vsync_q, vsync_d;
    logic [OUT_BITS-1:0] r_q, r_d, g_q, g_d, b_q, b_d;

    always_comb begin
        hsync_d = hs_al ? SYNC_POL : ~SYNC_POL;
        vsync_d = vs_al ? SYNC_POL : ~SYNC_POL;
        r_d     = '0;
        g_d     = '0;
        b_d     = '0;
        if (act_al && pix_valid) begin
            r_d = dither_ch(pix_r, bayer);
            g_d = dither_ch(pix_g, bayer);
            b_d = dither_ch(pix_b, bayer);
        end
    end

    always_ff @(posedge clk48 or posedge rst) begin
        if (rst) begin
            hsync_q <= ~SYNC_POL;
            vsync_q <= ~SYNC_POL;
            r_q     <= '0;
            g_q     <= '0;
            b_q     <= '0;
        end else begin
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            r_q     <= r_d;
            g_q     <= g_d;
            b_q     <= b_d;
        end
    end

    assign hsync = hsync_q;
    assign vsync = vsync_q;
    assign r_out = r_q;
    assign g_out = g_q;
    assign b_out = b_q;

endmodule

// File: tb/tb_vga_timing_dither.sv
module tb_vga_timing_dither;

    // Shrunk timing so several whole frames fit in a short run.
    localparam int HD = 16, HF = 2, HS = 3, HT = 24;
    localparam int VD = 6,  VF = 1, VS = 2, VT = 10;
    localparam int LA = 2;   // instance A: default colour path
    localparam int LB = 0;   // instance B: 8->4 bits, zero latency, active-high syncs

    logic clk48 = 1'b0;
    logic rst   = 1'b1;
    always #5 clk48 = ~clk48;

    logic [10:0] a_h, b_h;
    logic [9:0]  a_v, b_v;
    logic        a_ls, a_fs, b_ls, b_fs;
    logic [1:0]  a_fr, b_fr;
    logic [5:0]  a_pr, a_pg, a_pb;
    logic [7:0]  b_pr, b_pg, b_pb;
    logic        a_pv, b_pv;
    logic        a_hs, a_vs, b_hs, b_vs;
    logic [1:0]  a_ro, a_go, a_bo;
    logic [3:0]  b_ro, b_go, b_bo;

    vga_timing_dither #(
        .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_TOTAL(HT),
        .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_TOTAL(VT),
        .IN_BITS(6), .OUT_BITS(2), .PIPE_LAT(LA), .SYNC_POL(1'b0)
    ) u_a (
        .clk48(clk48), .rst(rst),
        .h_count(a_h), .v_count(a_v), .line_start(a_ls), .frame_start(a_fs), .frame(a_fr),
        .pix_r(a_pr), .pix_g(a_pg), .pix_b(a_pb), .pix_valid(a_pv),
        .hsync(a_hs), .vsync(a_vs), .r_out(a_ro), .g_out(a_go), .b_out(a_bo)
    );

    vga_timing_dither #(
        .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_TOTAL(HT),
        .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_TOTAL(VT),
        .IN_BITS(8), .OUT_BITS(4), .PIPE_LAT(LB), .SYNC_POL(1'b1)
    ) u_b (
        .clk48(clk48), .rst(rst),
        .h_count(b_h), .v_count(b_v), .line_start(b_ls), .frame_start(b_fs), .frame(b_fr),
        .pix_r(b_pr), .pix_g(b_pg), .pix_b(b_pb), .pix_valid(b_pv),
        .hsync(b_hs), .vsync(b_vs), .r_out(b_ro), .g_out(b_go), .b_out(b_bo)
    );

    int errors = 0;
    int checks = 0;

    // Colour presented in the previous cycle (feeds this cycle's pins).
    int pa_r, pa_g, pa_b, pa_v;
    int pb_r, pb_g, pb_b, pb_v;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Screen position of the m-th cycle after reset release.
    task automatic pos(input int m, output int h, output int v, output int f);
        h = m % HT;
        v = (m / HT) % VT;
        f = (m / (HT * VT)) % 4;
    endtask

    // Reference dither: 8x8 Bayer threshold, add, shift, clamp.
    function automatic int dith(input int c, input int h, input int v, input int f,
                                input int inb, input int outb);
        int i, j, a, m, d, t, r, mx;
        i = h % 8;
        j = v % 8;
`ifdef VGA_TEMPORAL_DITHER_EN
        i = i ^ (f % 2);
        j = j ^ ((f / 2) % 2);
`endif
        a = i ^ j;
        m = 0;
        for (int k = 0; k < 3; k++) begin
            m = m + (((a >> k) & 1) << (5 - 2 * k)) + (((i >> k) & 1) << (4 - 2 * k));
        end
        d  = inb - outb;
        t  = m / (1 << (6 - d));
        r  = (c + t) / (1 << d);
        mx = (1 << outb) - 1;
        return (r > mx) ? mx : r;
    endfunction

    task automatic expect_pins(input int n, input int lat, input int pol,
                               input int inb, input int outb,
                               input int pr, input int pg, input int pb, input int pv,
                               output int ehs, output int evs,
                               output int er, output int eg, output int eb);
        int h, v, f;
        ehs = 1 - pol; evs = 1 - pol; er = 0; eg = 0; eb = 0;
        if (n >= lat + 1) begin
            pos(n - lat - 1, h, v, f);
            if (h >= HD + HF && h < HD + HF + HS) ehs = pol;
            if (v >= VD + VF && v < VD + VF + VS) evs = pol;
            if (h < HD && v < VD && pv != 0) begin
                er = dith(pr, h, v, f, inb, outb);
                eg = dith(pg, h, v, f, inb, outb);
                eb = dith(pb, h, v, f, inb, outb);
            end
        end
    endtask

    function automatic int rnd_c(input int mx);
        case ($urandom_range(0, 3))
            0:       return 0;
            1:       return mx;
            default: return int'($urandom_range(0, mx));
        endcase
    endfunction

    task automatic check_reset(input string tag);
        chk({tag, "_a_h"},  32'(a_h),  0);
        chk({tag, "_a_v"},  32'(a_v),  0);
        chk({tag, "_a_fr"}, 32'(a_fr), 0);
        chk({tag, "_a_ls"}, 32'(a_ls), 0);
        chk({tag, "_a_fs"}, 32'(a_fs), 0);
        chk({tag, "_a_hs"}, 32'(a_hs), 1);
        chk({tag, "_a_vs"}, 32'(a_vs), 1);
        chk({tag, "_a_rgb"}, 32'({a_ro, a_go, a_bo}), 0);
        chk({tag, "_b_hs"}, 32'(b_hs), 0);
        chk({tag, "_b_vs"}, 32'(b_vs), 0);
        chk({tag, "_b_rgb"}, 32'({b_ro, b_go, b_bo}), 0);
    endtask

    // One cycle: entered just after the active edge (or reset release).
    task automatic step(input int n);
        int h, v, f, m;
        int ehs, evs, er, eg, eb;

        // Instance A: this cycle's colour belongs to counters n-LA.
        if (n >= LA) pos(n - LA, h, v, f);
        if (n >= LA && (n - LA) < HT && v == 0) begin
            a_pr = 6'd20; a_pg = 6'd63; a_pb = 6'd4; a_pv = 1'b1;
        end else begin
            a_pr = 6'(rnd_c(63)); a_pg = 6'(rnd_c(63)); a_pb = 6'(rnd_c(63));
            a_pv = ($urandom_range(0, 7) != 0);
        end
        // Instance B: zero latency, colour belongs to counters n.
        if (n < HT) begin
            b_pr = 8'd255; b_pg = 8'd0; b_pb = 8'd255; b_pv = 1'b1;
        end else begin
            b_pr = 8'(rnd_c(255)); b_pg = 8'(rnd_c(255)); b_pb = 8'(rnd_c(255));
            b_pv = ($urandom_range(0, 7) != 0);
        end

        @(negedge clk48);

        pos(n, h, v, f);
        chk("a_h",  32'(a_h),  32'(h));
        chk("a_v",  32'(a_v),  32'(v));
        chk("a_fr", 32'(a_fr), 32'(f));
        chk("a_ls", 32'(a_ls), (h == 0) ? 1 : 0);
        chk("a_fs", 32'(a_fs), (h == 0 && v == 0) ? 1 : 0);
        chk("b_h",  32'(b_h),  32'(h));
        chk("b_v",  32'(b_v),  32'(v));
        chk("b_fr", 32'(b_fr), 32'(f));
        chk("b_fs", 32'(b_fs), (h == 0 && v == 0) ? 1 : 0);

        expect_pins(n, LA, 0, 6, 2, pa_r, pa_g, pa_b, pa_v, ehs, evs, er, eg, eb);
        chk("a_hsync", 32'(a_hs), 32'(ehs));
        chk("a_vsync", 32'(a_vs), 32'(evs));
        chk("a_r", 32'(a_ro), 32'(er));
        chk("a_g", 32'(a_go), 32'(eg));
        chk("a_b", 32'(a_bo), 32'(eb));

        expect_pins(n, LB, 1, 8, 4, pb_r, pb_g, pb_b, pb_v, ehs, evs, er, eg, eb);
        chk("b_hsync", 32'(b_hs), 32'(ehs));
        chk("b_vsync", 32'(b_vs), 32'(evs));
        chk("b_r", 32'(b_ro), 32'(er));
        chk("b_g", 32'(b_go), 32'(eg));
        chk("b_b", 32'(b_bo), 32'(eb));

        // Hand-derived values on the first line after release.
        m = n - LA - 1;
        if (m >= 0 && m < HT) begin
            if (m == 0)  chk("dir_a_r_h0_c20", 32'(a_ro), 1);
            if (m == 7)  chk("dir_a_r_h7_c20", 32'(a_ro), 2);
            if (m == 7)  chk("dir_a_g_h7_sat", 32'(a_go), 3);
            if (m == 1)  chk("dir_a_b_h1_c4",  32'(a_bo), 1);
            if (m == HD) chk("dir_a_g_blank",  32'(a_go), 0);
        end
        m = n - LB - 1;
        if (m >= 0 && m < HT) begin
            chk("dir_b_r_c255", 32'(b_ro), (m < HD) ? 15 : 0);
            chk("dir_b_g_c0",   32'(b_go), 0);
        end

        pa_r = int'(a_pr); pa_g = int'(a_pg); pa_b = int'(a_pb); pa_v = int'(a_pv);
        pb_r = int'(b_pr); pb_g = int'(b_pg); pb_b = int'(b_pb); pb_v = int'(b_pv);

        @(posedge clk48);
        #1;
    endtask

    initial begin
        rst  = 1'b1;
        a_pr = '0; a_pg = '0; a_pb = '0; a_pv = 1'b0;
        b_pr = '0; b_pg = '0; b_pb = '0; b_pv = 1'b0;
        pa_r = 0; pa_g = 0; pa_b = 0; pa_v = 0;
        pb_r = 0; pb_g = 0; pb_b = 0; pb_v = 0;

        repeat (3) @(posedge clk48);
        @(negedge clk48);
        check_reset("por");
        @(posedge clk48);
        #1 rst = 1'b0;

        // Five-plus frames: covers vsync, frame 0->1 and 3->0 wrap.
        for (int n = 0; n < 5 * HT * VT + 50; n++) step(n);

        // Reset mid-line for 5 cycles, then restart from (0,0).
        rst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk48);
            check_reset("mid");
            @(posedge clk48);
        end
        #1 rst = 1'b0;
        for (int n = 0; n < 300; n++) step(n);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
